// File: rtl/response_tx_queue.sv
// ---------------------------------------------------------------------------
// response_tx_queue
//
// Downstream stage of the response handler. Response bytes (type byte, then
// data byte) are written into a small circular FIFO. A three-state sequencer
// passes them one at a time to the UART transmitter over a start/busy/done
// handshake. The handler can therefore emit back-to-back bytes while the UART
// is still shifting out an earlier frame.
//
// Parameters
//   DATA_WIDTH  width of one response byte
//   DEPTH       FIFO entries (power of two, >= 2)
//   CNT_W       width of level; derived from DEPTH, do not override
//
// Ports
//   clock           in   system clock, all logic on the rising edge
//   reset_n         in   asynchronous assert, synchronous release, active low
//   response_ready  in   write strobe, one byte pushed per cycle it is high
//   response        in   byte to queue, sampled while response_ready=1
//   tx_busy         in   UART TX is shifting a frame
//   tx_done         in   one-cycle pulse, UART TX finished its frame
//   tx_start        out  one-cycle pulse, UART TX loads tx_data
//   tx_data         out  byte for UART TX, stable from tx_start until tx_done
//   queue_empty     out  level == 0 (registered)
//   queue_full      out  level == DEPTH (registered)
//   overflow        out  sticky, a byte was dropped because the FIFO was full
//   level           out  bytes currently stored, 0..DEPTH (registered)
//
// Timing
//   A byte written into an empty FIFO at edge E0 (UART idle) reaches the
//   START state after edge E2. After tx_done the sequencer rests two cycles
//   in IDLE before the next tx_start. Both come from two launch qualifiers:
//   the head entry must have been resident for a full cycle, and the
//   sequencer must already have been in IDLE on the previous cycle.
// ---------------------------------------------------------------------------
module response_tx_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  response_ready,
  input  logic [DATA_WIDTH-1:0] response,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  queue_empty,
  output logic                  queue_full,
  output logic                  overflow,
  output logic [CNT_W-1:0]      level
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] LEVEL_FULL = CNT_W'(DEPTH);

  // Sequencer encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      level_next;

  // Launch qualifiers, see the header timing note.
  logic                  head_settled;
  logic                  idle_settled;

  logic                  pop;
  logic                  push;
  logic                  drop;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  // A pop is exactly the IDLE->START transition. The live queue_empty term
  // keeps the pop safe even if the settle flag were ever stale.
  assign pop  = (state == ST_IDLE) && idle_settled && head_settled &&
                !queue_empty && !tx_busy;

  // A write into a full FIFO still succeeds when the head leaves in the
  // same cycle, so the level stays at DEPTH and nothing is dropped.
  assign push = response_ready && (!queue_full || pop);
  assign drop = response_ready &&  queue_full  && !pop;

  assign tx_start = (state == ST_START);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default on entry, so
  // no path through the case statements can leave it unassigned (no latch).
  always_comb begin
    level_next = level;
    unique case ({push, pop})
      2'b10:   level_next = level + CNT_W'(1);
      2'b01:   level_next = level - CNT_W'(1);
      default: level_next = level;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (pop)     state_next = ST_START;
      ST_START:              state_next = ST_WAIT;
      // tx_done is acted on only here. A stray pulse in IDLE or START,
      // including the tail of a frame that was in flight across a reset,
      // has no effect.
      ST_WAIT:  if (tx_done) state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Storage array
  // -------------------------------------------------------------------------
  // NOTE: the data array has no reset. Entries are only read after they have
  // been written, and the reset-able pointers and level fully define which
  // entries are valid. Leaving the array out of reset keeps it a plain RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= response;
    end
  end

  // -------------------------------------------------------------------------
  // Pointers, level and status flags
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge, whatever the order
  // of the statements.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      queue_empty <= 1'b1;
      queue_full  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level       <= level_next;
      queue_empty <= (level_next == '0);
      queue_full  <= (level_next == LEVEL_FULL);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer and transmit data register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      tx_data      <= '0;
      head_settled <= 1'b0;
      idle_settled <= 1'b0;
    end else begin
      state        <= state_next;
      // head_settled is queue_empty delayed by one cycle: the head entry has
      // been resident for at least one full cycle.
      head_settled <= !queue_empty;
      idle_settled <= (state == ST_IDLE);
      // tx_data changes only on a pop, which happens only in IDLE. It
      // therefore holds through START and WAIT until the frame completes.
      if (pop) begin
        tx_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_response_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_response_tx_queue
//
// Directed bench for response_tx_queue. A small UART model answers each
// tx_start with busy for 10 cycles, then a one-cycle tx_done. It logs every
// byte launched and the cycle numbers of starts and dones. The bench drives
// inputs and samples outputs on the falling edge. Polling of the model's own
// state happens just after the rising edge, where the model is quiet.
// ---------------------------------------------------------------------------
module tb_response_tx_queue;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       response_ready = 1'b0;
  logic [7:0] response = 8'h00;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       queue_empty;
  logic       queue_full;
  logic       overflow;
  logic [2:0] level;

  // Stimulus-side controls layered over the UART model
  logic force_busy = 1'b0;
  logic stray_done = 1'b0;
  logic uart_busy  = 1'b0;
  logic uart_done  = 1'b0;
  int   uart_cnt   = 0;
  int   cyc        = 0;

  logic [7:0] got[$];
  int         start_cyc[$];
  int         done_cyc[$];

  int tests_run = 0;
  int failed    = 0;

  assign tx_busy = uart_busy | force_busy;
  assign tx_done = uart_done | stray_done;

  response_tx_queue #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .response_ready (response_ready),
    .response       (response),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .queue_empty    (queue_empty),
    .queue_full     (queue_full),
    .overflow       (overflow),
    .level          (level)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  // UART model. A frame in flight is not aborted by the queue's reset.
  always @(negedge clock) begin
    uart_done = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt = uart_cnt - 1;
      if (uart_cnt == 0) begin
        uart_done = 1'b1;
        uart_busy = 1'b0;
        done_cyc.push_back(cyc);
      end
    end else if (tx_start) begin
      uart_busy = 1'b1;
      uart_cnt  = 10;
      got.push_back(tx_data);
      start_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    got.delete();
    start_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    response_ready = 1'b0;
    repeat (2) @(negedge clock);
    clear_log();
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Wait until n bytes were launched, the UART is idle and the FIFO is empty.
  task automatic wait_drain(input int n, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clock);
      #1;
      if (got.size() >= n && uart_cnt == 0 && level == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!ok) begin
      failed++;
      $display("FAIL %s_drain: launched %0d bytes, level %0d; required %0d bytes, level 0",
               name, got.size(), level, n);
    end
    @(negedge clock);
  endtask

  // 1: reset with response_ready toggling
  task automatic test_reset();
    #2 reset_n = 1'b0;
    response = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      response_ready = ~response_ready;
    end
    @(negedge clock);
    tests_run++; if (level !== 3'd0) begin failed++; $display("FAIL reset_level: got %0d, want 0", level); end
    tests_run++; if (queue_empty !== 1'b1) begin failed++; $display("FAIL reset_empty: got %b, want 1", queue_empty); end
    tests_run++; if (tx_start !== 1'b0) begin failed++; $display("FAIL reset_tx_start: got %b, want 0", tx_start); end
    tests_run++; if (tx_data !== 8'h00) begin failed++; $display("FAIL reset_tx_data: got %h, want 00", tx_data); end
    tests_run++; if (overflow !== 1'b0) begin failed++; $display("FAIL reset_overflow: got %b, want 0", overflow); end
    response_ready = 1'b0;
    clear_log();
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // 2: two bytes, latency and inter-frame gap
  task automatic test_single_pair();
    clear_log();
    response_ready = 1'b1;
    response = 8'h12;
    @(negedge clock);                       // after E0
    tests_run++; if (level !== 3'd1) begin failed++; $display("FAIL pair_level_e0: got %0d, want 1", level); end
    response = 8'h5A;
    @(negedge clock);                       // after E1
    response_ready = 1'b0;
    tests_run++; if (tx_start !== 1'b0) begin failed++; $display("FAIL pair_start_e1: got %b, want 0", tx_start); end
    @(negedge clock);                       // after E2
    tests_run++; if (tx_start !== 1'b1) begin failed++; $display("FAIL pair_start_e2: got %b, want 1", tx_start); end
    tests_run++; if (tx_data !== 8'h12) begin failed++; $display("FAIL pair_data_e2: got %h, want 12", tx_data); end
    tests_run++; if (level !== 3'd1) begin failed++; $display("FAIL pair_level_e2: got %0d, want 1", level); end
    wait_drain(2, 200, "pair");
    tests_run++; if (got.size() != 2) begin failed++; $display("FAIL pair_count: got %0d, want 2", got.size()); end
    if (got.size() >= 2) begin
      tests_run++; if (got[0] !== 8'h12) begin failed++; $display("FAIL pair_byte0: got %h, want 12", got[0]); end
      tests_run++; if (got[1] !== 8'h5A) begin failed++; $display("FAIL pair_byte1: got %h, want 5a", got[1]); end
    end
    if (start_cyc.size() >= 2 && done_cyc.size() >= 1) begin
      tests_run++;
      if (start_cyc[1] - done_cyc[0] != 3) begin
        failed++;
        $display("FAIL pair_gap: done-to-start %0d cycles, want 3", start_cyc[1] - done_cyc[0]);
      end
    end
    tests_run++; if (queue_empty !== 1'b1) begin failed++; $display("FAIL pair_empty: got %b, want 1", queue_empty); end
  endtask

  // 3: overflow while the UART is held busy
  task automatic test_overflow();
    clear_log();
    force_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      response_ready = 1'b1;
      response = 8'(i);
      @(negedge clock);
    end
    response_ready = 1'b0;
    @(negedge clock);
    tests_run++; if (level !== 3'd4) begin failed++; $display("FAIL ovf_level: got %0d, want 4", level); end
    tests_run++; if (queue_full !== 1'b1) begin failed++; $display("FAIL ovf_full: got %b, want 1", queue_full); end
    tests_run++; if (overflow !== 1'b1) begin failed++; $display("FAIL ovf_flag: got %b, want 1", overflow); end
    tests_run++; if (got.size() != 0) begin failed++; $display("FAIL ovf_held: got %0d launches, want 0", got.size()); end
    force_busy = 1'b0;
    wait_drain(4, 300, "ovf");
    tests_run++; if (got.size() != 4) begin failed++; $display("FAIL ovf_count: got %0d, want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      tests_run++;
      if (got[i] !== 8'(i + 1)) begin failed++; $display("FAIL ovf_byte%0d: got %h, want %h", i, got[i], 8'(i + 1)); end
    end
    tests_run++; if (overflow !== 1'b1) begin failed++; $display("FAIL ovf_sticky: got %b, want 1", overflow); end
  endtask

  // 4: simultaneous push and pop with the FIFO full
  task automatic test_full_push_pop();
    logic [7:0] exp_q[$];
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h77};
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      response_ready = 1'b1;
      response = exp_q[i];
      @(negedge clock);
    end
    response_ready = 1'b0;
    repeat (2) @(negedge clock);
    force_busy = 1'b0;
    response_ready = 1'b1;
    response = 8'h77;
    @(negedge clock);
    response_ready = 1'b0;
    tests_run++; if (level !== 3'd4) begin failed++; $display("FAIL full_level: got %0d, want 4", level); end
    tests_run++; if (overflow !== 1'b0) begin failed++; $display("FAIL full_overflow: got %b, want 0", overflow); end
    tests_run++; if (tx_start !== 1'b1) begin failed++; $display("FAIL full_start: got %b, want 1", tx_start); end
    tests_run++; if (tx_data !== 8'h31) begin failed++; $display("FAIL full_data: got %h, want 31", tx_data); end
    wait_drain(5, 400, "full");
    tests_run++; if (got.size() != 5) begin failed++; $display("FAIL full_count: got %0d, want 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      tests_run++;
      if (got[i] !== exp_q[i]) begin failed++; $display("FAIL full_byte%0d: got %h, want %h", i, got[i], exp_q[i]); end
    end
  endtask

  // 5: stray tx_done in IDLE, then 3*DEPTH bytes through a wrapping FIFO
  task automatic test_stray_and_wrap();
    bit ok;
    clear_log();
    stray_done = 1'b1;
    @(negedge clock);
    stray_done = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++; if (got.size() != 0) begin failed++; $display("FAIL stray_start: got %0d launches, want 0", got.size()); end
    tests_run++; if (queue_empty !== 1'b1) begin failed++; $display("FAIL stray_empty: got %b, want 1", queue_empty); end
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (!queue_full) begin ok = 1'b1; break; end
        @(negedge clock);
      end
      if (!ok) begin
        tests_run++;
        failed++;
        $display("FAIL wrap_stall: queue_full stuck at byte %0d, want it to clear", i);
      end
      response_ready = 1'b1;
      response = 8'hA0 + 8'(i);
      @(negedge clock);
      response_ready = 1'b0;
    end
    wait_drain(12, 1000, "wrap");
    tests_run++; if (got.size() != 12) begin failed++; $display("FAIL wrap_count: got %0d, want 12", got.size()); end
    for (int i = 0; i < got.size() && i < 12; i++) begin
      tests_run++;
      if (got[i] !== 8'hA0 + 8'(i)) begin failed++; $display("FAIL wrap_byte%0d: got %h, want %h", i, got[i], 8'hA0 + 8'(i)); end
    end
    tests_run++; if (overflow !== 1'b0) begin failed++; $display("FAIL wrap_overflow: got %b, want 0", overflow); end
  endtask

  // 6: reset during WAIT with three bytes queued
  task automatic test_reset_mid();
    clear_log();
    for (int i = 0; i < 4; i++) begin
      response_ready = 1'b1;
      response = 8'hC1 + 8'(i);
      @(negedge clock);
    end
    response_ready = 1'b0;
    tests_run++; if (level !== 3'd3) begin failed++; $display("FAIL mid_setup_level: got %0d, want 3", level); end
    reset_n = 1'b0;
    @(negedge clock);
    tests_run++; if (level !== 3'd0) begin failed++; $display("FAIL mid_level: got %0d, want 0", level); end
    tests_run++; if (queue_empty !== 1'b1) begin failed++; $display("FAIL mid_empty: got %b, want 1", queue_empty); end
    tests_run++; if (tx_data !== 8'h00) begin failed++; $display("FAIL mid_tx_data: got %h, want 00", tx_data); end
    @(negedge clock);
    clear_log();
    reset_n = 1'b1;
    @(negedge clock);
    response_ready = 1'b1;
    response = 8'hD1;
    @(negedge clock);
    response = 8'hD2;
    @(negedge clock);
    response_ready = 1'b0;
    wait_drain(2, 300, "mid");
    repeat (3) @(negedge clock);
    tests_run++; if (got.size() != 2) begin failed++; $display("FAIL mid_count: got %0d, want 2", got.size()); end
    if (got.size() >= 2) begin
      tests_run++; if (got[0] !== 8'hD1) begin failed++; $display("FAIL mid_byte0: got %h, want d1", got[0]); end
      tests_run++; if (got[1] !== 8'hD2) begin failed++; $display("FAIL mid_byte1: got %h, want d2", got[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_overflow();
    test_full_push_pop();
    test_stray_and_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
